// File: rtl/calc_if.sv
// Keypad, ALU handshake and display bundle for the calculator sequencer.
// master drives keys and ALU completion; slave is the sequencer.
interface calc_if #(
    parameter int WIDTH = 16
);
    logic             key_valid;
    logic [3:0]       key_code;
    logic             alu_done;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [1:0]       alu_op;
    logic             alu_start;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             error;
    logic [WIDTH-1:0] display_value;

    modport master (
        output key_valid, key_code, alu_done, alu_result,
        input  operand_a, operand_b, alu_op, alu_start, busy,
               result, result_valid, error, display_value
    );

    modport slave (
        input  key_valid, key_code, alu_done, alu_result,
        output operand_a, operand_b, alu_op, alu_start, busy,
               result, result_valid, error, display_value
    );
endinterface

// File: rtl/calc_sequencer.sv
// Keypad-driven calculator sequencer: builds operands, starts the ALU, waits for done with timeout, holds result.
// All outputs registered; define CALC_RESULT_CHAIN_EN to let an op key in SHOW chain from the last result.
module calc_sequencer #(
    parameter int WIDTH   = 16,
    parameter int DIGITS  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic   clk,
    input  logic   rst_n,
    calc_if.slave  bus
);
    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_GET_A, S_GET_B, S_EXEC, S_WAIT, S_SHOW
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, disp_q, disp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [1:0]       op_q, op_d;
    logic             start_q, start_d, busy_q, busy_d;
    logic             rv_q, rv_d, err_q, err_d;

    logic             is_digit, is_op, is_eq, is_clr, can_digit, tmo_hit;
    logic             full_clr, load_digit;
    logic [1:0]       op_code;
    logic [WIDTH-1:0] digit_w, acc_a, acc_b;

    assign is_digit  = bus.key_valid && (bus.key_code <= 4'd9);
    assign is_op     = bus.key_valid && (bus.key_code >= 4'd10) && (bus.key_code <= 4'd13);
    assign is_eq     = bus.key_valid && (bus.key_code == 4'd14);
    assign is_clr    = bus.key_valid && (bus.key_code == 4'd15);
    // Codes 10..13 map to 00..11 through bits 2 and 0.
    assign op_code   = {bus.key_code[2], bus.key_code[0]};
    assign digit_w   = {{(WIDTH-4){1'b0}}, bus.key_code};
    assign acc_a     = a_q * WIDTH'(10) + digit_w;
    assign acc_b     = b_q * WIDTH'(10) + digit_w;
    assign can_digit = (cnt_q != CW'(DIGITS));
    assign tmo_hit   = (tmo_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_GET_A;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            disp_q  <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            op_q    <= 2'b00;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            disp_q  <= disp_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            op_q    <= op_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_GET_A: if (is_op) state_d = S_GET_B;
            S_GET_B: begin
                if (is_clr)                           state_d = S_GET_A;
                else if (is_eq && (cnt_q != '0))      state_d = S_EXEC;
            end
            S_EXEC:  state_d = S_WAIT;
            S_WAIT: begin
                if (is_clr)                           state_d = S_GET_A;
                else if (bus.alu_done || tmo_hit)     state_d = S_SHOW;
            end
            S_SHOW: begin
                if (is_digit || is_clr)               state_d = S_GET_A;
`ifdef CALC_RESULT_CHAIN_EN
                else if (is_op)                       state_d = S_GET_B;
`endif
            end
            default: state_d = S_GET_A;
        endcase
    end

    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        op_d       = op_q;
        rv_d       = rv_q;
        err_d      = err_q;
        full_clr   = 1'b0;
        load_digit = 1'b0;
        case (state_q)
            S_GET_A: begin
                if (is_digit && can_digit) begin
                    a_d   = acc_a;
                    cnt_d = cnt_q + CW'(1);
                end else if (is_op) begin
                    op_d  = op_code;
                    b_d   = '0;
                    cnt_d = '0;
                end else if (is_clr) begin
                    a_d   = '0;
                    cnt_d = '0;
                end
            end
            S_GET_B: begin
                if (is_digit && can_digit) begin
                    b_d   = acc_b;
                    cnt_d = cnt_q + CW'(1);
                end else if (is_op && (cnt_q == '0)) begin
                    op_d  = op_code;
                end else if (is_clr) begin
                    full_clr = 1'b1;
                end
            end
            S_EXEC: tmo_d = '0;
            S_WAIT: begin
                tmo_d = tmo_q + TW'(1);
                if (is_clr) begin
                    full_clr = 1'b1;
                end else if (bus.alu_done) begin
                    res_d = bus.alu_result;
                    rv_d  = 1'b1;
                    err_d = 1'b0;
                end else if (tmo_hit) begin
                    res_d = '0;
                    rv_d  = 1'b0;
                    err_d = 1'b1;
                end
            end
            S_SHOW: begin
                if (is_digit) begin
                    full_clr   = 1'b1;
                    load_digit = 1'b1;
                end else if (is_clr) begin
                    full_clr = 1'b1;
                end
`ifdef CALC_RESULT_CHAIN_EN
                else if (is_op) begin
                    a_d   = res_q;
                    cnt_d = '0;
                    op_d  = op_code;
                    b_d   = '0;
                end
`endif
            end
            default: full_clr = 1'b1;
        endcase
        if (full_clr) begin
            a_d   = '0;
            b_d   = '0;
            cnt_d = '0;
            op_d  = 2'b00;
            res_d = '0;
            rv_d  = 1'b0;
            err_d = 1'b0;
        end
        if (load_digit) begin
            a_d   = digit_w;
            cnt_d = CW'(1);
        end
        if (state_d != S_SHOW) begin
            rv_d  = 1'b0;
            err_d = 1'b0;
        end
        start_d = (state_d == S_EXEC);
        busy_d  = (state_d == S_EXEC) || (state_d == S_WAIT);
        case (state_d)
            S_GET_B: disp_d = (cnt_d != '0) ? b_d : a_d;
            S_SHOW:  disp_d = res_d;
            default: disp_d = a_d;
        endcase
    end

    assign bus.operand_a     = a_q;
    assign bus.operand_b     = b_q;
    assign bus.alu_op        = op_q;
    assign bus.alu_start     = start_q;
    assign bus.busy          = busy_q;
    assign bus.result        = res_q;
    assign bus.result_valid  = rv_q;
    assign bus.error         = err_q;
    assign bus.display_value = disp_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// Directed-key bench for calc_sequencer; expected ALU starts and result displays go through scoreboard queues.
module tb_calc_sequencer;
    localparam int W = 16;
    localparam logic [3:0] K_ADD = 4'd10, K_SUB = 4'd11, K_AND = 4'd12, K_ORR = 4'd13;
    localparam logic [3:0] K_EQ  = 4'd14, K_CLR = 4'd15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    calc_if #(.WIDTH(W)) bus ();
    calc_if #(.WIDTH(W)) bus5 ();

    calc_sequencer #(.WIDTH(W), .DIGITS(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    calc_sequencer #(.WIDTH(W), .DIGITS(5), .TIMEOUT(8)) dut5 (
        .clk(clk), .rst_n(rst_n), .bus(bus5)
    );

    assign bus5.key_valid  = bus.key_valid;
    assign bus5.key_code   = bus.key_code;
    assign bus5.alu_done   = 1'b0;
    assign bus5.alu_result = '0;

    typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic [1:0] op; } start_t;
    typedef struct { logic [W-1:0] res; logic rv; logic err; logic [W-1:0] disp; } show_t;

    start_t start_q[$];
    show_t  show_q[$];
    start_t se;
    show_t  sh;
    int     checks = 0;
    int     errors = 0;
    logic   show_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic exp_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        start_t s;
        s.a = a; s.b = b; s.op = op;
        start_q.push_back(s);
    endtask

    task automatic exp_show(input logic [W-1:0] res, input logic rv, input logic err,
                            input logic [W-1:0] disp);
        show_t s;
        s.res = res; s.rv = rv; s.err = err; s.disp = disp;
        show_q.push_back(s);
    endtask

    // Monitor: every start pulse and every entry into the result display is matched to a queued expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            show_prev = 1'b0;
        end else begin
            if (bus.alu_start) begin
                if (start_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_alu_start: got 1 required 0");
                end else begin
                    se = start_q.pop_front();
                    chk("start_operand_a", bus.operand_a, se.a);
                    chk("start_operand_b", bus.operand_b, se.b);
                    chk("start_alu_op", bus.alu_op, se.op);
                end
            end
            if ((bus.result_valid || bus.error) && !show_prev) begin
                if (show_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_show: got result_valid=%0d error=%0d required none",
                             bus.result_valid, bus.error);
                end else begin
                    sh = show_q.pop_front();
                    chk("show_result", bus.result, sh.res);
                    chk("show_result_valid", bus.result_valid, sh.rv);
                    chk("show_error", bus.error, sh.err);
                    chk("show_display", bus.display_value, sh.disp);
                end
            end
            show_prev = bus.result_valid || bus.error;
        end
    end

    task automatic press(input logic [3:0] c);
        bus.key_valid = 1'b1;
        bus.key_code  = c;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    task automatic run_alu(input int lat, input logic [W-1:0] val);
        int n = 0;
        while (!bus.alu_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.alu_start) begin
            checks++;
            errors++;
            $display("FAIL alu_start_wait: got 0 required 1");
        end else begin
            repeat (lat) @(negedge clk);
            bus.alu_done   = 1'b1;
            bus.alu_result = val;
            @(negedge clk);
            bus.alu_done   = 1'b0;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_operand_a"}, bus.operand_a, 0);
        chk({tag, "_operand_b"}, bus.operand_b, 0);
        chk({tag, "_alu_op"}, bus.alu_op, 0);
        chk({tag, "_alu_start"}, bus.alu_start, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_result"}, bus.result, 0);
        chk({tag, "_result_valid"}, bus.result_valid, 0);
        chk({tag, "_error"}, bus.error, 0);
        chk({tag, "_display"}, bus.display_value, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus.key_valid  = 1'b0;
        bus.key_code   = 4'd0;
        bus.alu_done   = 1'b0;
        bus.alu_result = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Digit limit (DIGITS=4) and modulo wrap (DIGITS=5)
        press(9); press(9); press(9); press(9); press(9);
        chk("digits4_operand_a", bus.operand_a, 9999);
        chk("digits4_display", bus.display_value, 9999);
        chk("digits5_wrap_operand_a", bus5.operand_a, 34463);
        press(K_CLR);
        chk("clear_a", bus.operand_a, 0);

        // 12 + 34 = 46
        press(1); press(2);
        chk("disp_a12", bus.display_value, 12);
        press(K_ADD);
        chk("disp_after_op", bus.display_value, 12);
        press(3); press(4);
        chk("disp_b34", bus.display_value, 34);
        exp_start(12, 34, 2'b00);
        exp_show(46, 1'b1, 1'b0, 46);
        press(K_EQ);
        chk("start_latency", bus.alu_start, 1);
        chk("busy_exec", bus.busy, 1);
        run_alu(3, 46);
        repeat (2) @(negedge clk);
        chk("show_hold_valid", bus.result_valid, 1);
        chk("show_hold_display", bus.display_value, 46);
        chk("show_busy", bus.busy, 0);
        press(K_CLR);
        chk("clr_show_valid", bus.result_valid, 0);
        chk("clr_show_display", bus.display_value, 0);

        // Timeout: 7 - 2 with no alu_done
        press(7); press(K_SUB); press(2);
        exp_start(7, 2, 2'b01);
        exp_show(0, 1'b0, 1'b1, 0);
        press(K_EQ);
        n = 0;
        while (bus.busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_busy_cycles", n, 9);
        chk("timeout_error", bus.error, 1);
        chk("timeout_result", bus.result, 0);
        chk("timeout_valid", bus.result_valid, 0);
        press(K_CLR);
        chk("timeout_error_cleared", bus.error, 0);

        // Op replacement before B digits, late op ignored, EQUALS without B
        press(4); press(K_ADD); press(K_SUB); press(6);
        exp_start(4, 6, 2'b01);
        exp_show(16'hFFFE, 1'b1, 1'b0, 16'hFFFE);
        press(K_EQ);
        run_alu(2, 16'hFFFE);
        press(K_CLR);
        press(4); press(K_ADD); press(6); press(K_SUB);
        exp_start(4, 6, 2'b00);
        exp_show(10, 1'b1, 1'b0, 10);
        press(K_EQ);
        run_alu(1, 10);
        press(K_CLR);
        press(4); press(K_ADD); press(K_EQ);
        repeat (3) @(negedge clk);
        chk("eq_no_b_busy", bus.busy, 0);
        chk("eq_no_b_display", bus.display_value, 4);
        press(K_CLR);

        // CLEAR in WAIT together with alu_done: CLEAR wins, late done ignored
        press(8); press(K_ORR); press(1);
        exp_start(8, 1, 2'b11);
        press(K_EQ);
        @(negedge clk);
        bus.key_valid  = 1'b1;
        bus.key_code   = K_CLR;
        bus.alu_done   = 1'b1;
        bus.alu_result = 99;
        @(negedge clk);
        bus.key_valid  = 1'b0;
        bus.alu_done   = 1'b0;
        check_zero("abort");
        bus.alu_done = 1'b1;
        @(negedge clk);
        bus.alu_done = 1'b0;
        @(negedge clk);
        chk("late_done_result", bus.result, 0);
        chk("late_done_valid", bus.result_valid, 0);

        // Asynchronous reset while waiting on the ALU
        press(3); press(K_AND); press(5);
        exp_start(3, 5, 2'b10);
        press(K_EQ);
        @(negedge clk);
        chk("wait_busy", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1 check_zero("midwait_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        press(2);
        chk("first_key_after_rst", bus.operand_a, 2);
        press(K_CLR);

        // Result chaining: 5 + 3 = then + 2 =
        press(5); press(K_ADD); press(3);
        exp_start(5, 3, 2'b00);
        exp_show(8, 1'b1, 1'b0, 8);
        press(K_EQ);
        run_alu(2, 8);
        press(K_ADD);
`ifdef CALC_RESULT_CHAIN_EN
        chk("chain_display", bus.display_value, 8);
        exp_start(8, 2, 2'b00);
        exp_show(10, 1'b1, 1'b0, 10);
        press(2);
        press(K_EQ);
        run_alu(1, 10);
`else
        chk("chain_off_still_show", bus.result_valid, 1);
        press(2);
        chk("chain_off_new_a", bus.operand_a, 2);
        chk("chain_off_left_show", bus.result_valid, 0);
        press(K_EQ);
        repeat (3) @(negedge clk);
        chk("chain_off_no_busy", bus.busy, 0);
`endif
        repeat (3) @(negedge clk);
        chk("start_queue_drained", start_q.size(), 0);
        chk("show_queue_drained", show_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
